toggle_handshake_responder: RTL and testbench

Receiving end of the two-phase (toggle) request/acknowledge link driven by a T-flip-flop-based initiator. The initiator flips `req_tog` once per word and holds `req_data` stable until it sees `ack_tog` flip. This block synchronizes the request toggle, captures the word, returns an acknowledge toggle, and buffers words in a small FIFO. The FIFO drains to a downstream valid/ready consumer. It sits on the local-clock side of the link.

---
 rtl/toggle_handshake_responder.sv | 121 ++++++++++++
 tb/tb_toggle_handshake_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_handshake_responder.sv
// toggle_handshake_responder
//   Receiving end of a two-phase (toggle) request/acknowledge link. The
//   request toggle is synchronized into clk, each new toggle captures
//   req_data into a small FIFO and flips ack_tog back to the initiator.
//   The FIFO drains to a valid/ready consumer.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   req_tog    request toggle from the initiator (asynchronous to clk)
//   req_data   word from the initiator, stable while a request is pending
//   ack_tog    registered acknowledge toggle to the initiator
//   req_event  one-cycle pulse per detected toggle of the synchronized request
//   out_valid  FIFO head word is valid
//   out_data   FIFO head word
//   out_ready  consumer accepts the head word when high with out_valid
//   level      number of words currently held in the FIFO
//
// state      | meaning
// IDLE       | no pending request, or pending request captured this cycle
// WAIT_SPACE | request pending but FIFO full; ack_tog withheld
module toggle_handshake_responder #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_tog,
  input  logic [DATA_W-1:0]        req_data,
  output logic                     ack_tog,
  output logic                     req_event,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE       = 1'b0,
    WAIT_SPACE = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_sync;
  logic                   req_sync_d;
  logic                   pend;
  logic                   full;
  logic                   capture;
  logic                   pop;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [DATA_W-1:0]      mem [DEPTH];

  assign req_sync  = sync_q[SYNC_STAGES-1];
  assign pend      = (req_sync != ack_tog);
  // Uses the registered level: a pop in the same cycle cannot open a slot.
  assign full      = (level == FULL_LEVEL);
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (pend) begin
          if (full) state_nxt = WAIT_SPACE;
          else      capture   = 1'b1;
        end
      end
      WAIT_SPACE: begin
        if (!pend) begin
          state_nxt = IDLE;
        end else if (!full) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync_q     <= '0;
      req_sync_d <= 1'b0;
      req_event  <= 1'b0;
      ack_tog    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state      <= state_nxt;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], req_tog};
      req_sync_d <= req_sync;
      req_event  <= req_sync ^ req_sync_d;
      if (capture) begin
        mem[wr_ptr] <= req_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        // After this edge ack_tog equals req_sync, so pend drops.
        ack_tog     <= ~ack_tog;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({capture, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_handshake_responder.sv
module tb_toggle_handshake_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_tog;
  logic [7:0] req_data;
  logic       ack_tog;
  logic       req_event;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] level;

  int  n_checks = 0;
  int  n_fail   = 0;
  logic exp_ack;

  toggle_handshake_responder #(.DATA_W(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_tog   (req_tog),
    .req_data  (req_data),
    .ack_tog   (ack_tog),
    .req_event (req_event),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled at negedge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One toggle; with space available the capture lands on the third edge.
  task automatic send(input logic [7:0] d);
    req_data = d;
    req_tog  = ~req_tog;
    cyc(); cyc(); cyc();
    exp_ack = ~exp_ack;
    check("send_ack", 32'(ack_tog), 32'(exp_ack));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_tog   = 1'b1;
    req_data  = 8'h3C;
    out_ready = 1'b0;
    exp_ack   = 1'b0;

    // Reset held 3 cycles with req_tog high
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_ack",   32'(ack_tog),   32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_level", 32'(level),     32'd0);
      check("rst_event", 32'(req_event), 32'd0);
      check("rst_data",  32'(out_data),  32'd0);
    end
    rst_n = 1'b1;
    cyc();
    check("rel_e0_ack", 32'(ack_tog), 32'd0);
    cyc();
    check("rel_e1_ack", 32'(ack_tog), 32'd0);
    cyc();
    exp_ack = 1'b1;
    check("rel_e2_ack",   32'(ack_tog),   32'd1);
    check("rel_e2_level", 32'(level),     32'd1);
    check("rel_e2_data",  32'(out_data),  32'h3C);
    check("rel_e2_event", 32'(req_event), 32'd1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("rel_pop_level", 32'(level),     32'd0);
    check("rel_pop_valid", 32'(out_valid), 32'd0);

    // Single transfer, edge-by-edge
    req_data = 8'hA5;
    req_tog  = ~req_tog;
    cyc();
    check("st_e0_ack",   32'(ack_tog),   32'd1);
    check("st_e0_event", 32'(req_event), 32'd0);
    cyc();
    check("st_e1_ack",   32'(ack_tog),   32'd1);
    check("st_e1_event", 32'(req_event), 32'd0);
    check("st_e1_valid", 32'(out_valid), 32'd0);
    cyc();
    exp_ack = 1'b0;
    check("st_e2_ack",   32'(ack_tog),   32'd0);
    check("st_e2_level", 32'(level),     32'd1);
    check("st_e2_valid", 32'(out_valid), 32'd1);
    check("st_e2_data",  32'(out_data),  32'hA5);
    check("st_e2_event", 32'(req_event), 32'd1);
    cyc();
    check("st_e3_event", 32'(req_event), 32'd0);
    check("st_e3_ack",   32'(ack_tog),   32'd0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("st_pop_level", 32'(level), 32'd0);

    // Fill and stall
    for (int i = 1; i <= 4; i++) begin
      send(8'(i));
      check("fill_level", 32'(level), 32'(i));
    end
    req_data = 8'h05;
    req_tog  = ~req_tog;
    cyc(); cyc();
    check("stall_event", 32'(req_event), 32'd0);
    cyc();
    check("stall_event_fires", 32'(req_event), 32'd1);
    check("stall_ack",   32'(ack_tog), 32'(exp_ack));
    check("stall_level", 32'(level),   32'd4);
    cyc(); cyc(); cyc();
    check("stall_ack_hold",   32'(ack_tog), 32'(exp_ack));
    check("stall_level_hold", 32'(level),   32'd4);
    check("stall_head",       32'(out_data), 32'h01);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("free_level", 32'(level),   32'd3);
    check("free_ack",   32'(ack_tog), 32'(exp_ack));
    cyc();
    exp_ack = ~exp_ack;
    check("late_cap_ack",   32'(ack_tog),  32'(exp_ack));
    check("late_cap_level", 32'(level),    32'd4);
    check("late_cap_head",  32'(out_data), 32'h02);

    // Drain order
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data",  32'(out_data),  32'(i));
      cyc();
    end
    out_ready = 1'b0;
    check("drain_level", 32'(level),     32'd0);
    check("drain_valid_end", 32'(out_valid), 32'd0);

    // Pointer wrap: three fill/drain rounds
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++) send(8'(8'h10 * (r + 1) + j));
      check("wrap_full", 32'(level), 32'd4);
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
        check("wrap_data", 32'(out_data), 32'(8'h10 * (r + 1) + j));
        cyc();
      end
      out_ready = 1'b0;
      check("wrap_empty", 32'(level), 32'd0);
    end

    // Simultaneous push and pop at level 2
    send(8'hA1);
    send(8'hA2);
    check("sim_pre_level", 32'(level), 32'd2);
    req_data = 8'hA3;
    req_tog  = ~req_tog;
    cyc(); cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    exp_ack = ~exp_ack;
    check("sim_ack",   32'(ack_tog),  32'(exp_ack));
    check("sim_level", 32'(level),    32'd2);
    check("sim_head",  32'(out_data), 32'hA2);
    out_ready = 1'b1;
    cyc();
    check("sim_next", 32'(out_data), 32'hA3);
    cyc();
    out_ready = 1'b0;
    check("sim_empty", 32'(level), 32'd0);

    // Reset mid-transfer with 3 words buffered
    send(8'hB1);
    send(8'hB2);
    send(8'hB3);
    check("mid_level", 32'(level), 32'd3);
    req_data = 8'hB4;
    req_tog  = ~req_tog;
    cyc();
    rst_n   = 1'b0;
    req_tog = 1'b0;
    cyc();
    check("mid_rst_ack",   32'(ack_tog),   32'd0);
    check("mid_rst_level", 32'(level),     32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    check("mid_rst_event", 32'(req_event), 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("post_rst_ack",   32'(ack_tog),   32'd0);
      check("post_rst_level", 32'(level),     32'd0);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_event", 32'(req_event), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
